// File: rtl/debug_pkg.sv
// Shared definitions for the debug command link: opcodes, reader state encoding, err bit indices.
// Also used by the UART writer, so keep encodings stable.
package debug_pkg;

    localparam logic [7:0] OP_A = 8'h41;
    localparam logic [7:0] OP_B = 8'h42;
    localparam logic [7:0] OP_M = 8'h4D;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_S = 8'h53;

    localparam int ERR_UNKNOWN = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_OVERRUN = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/debug_cmd_reader_if.sv
// Byte-in / command-out bundle of the debug command reader.
// Handshake: a command transfers on a rising clk edge where cmd_valid and cmd_ready are both high; cmd_opcode/cmd_payload hold while cmd_valid is high.
interface debug_cmd_reader_if;
    import debug_pkg::*;

    logic [7:0]  rx_data;
    logic        rx_data_rdy;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_payload;
    logic        busy;
    logic [2:0]  err;
    state_t      dbg_state;

    modport master (
        input  rx_data, rx_data_rdy, cmd_ready,
        output cmd_valid, cmd_opcode, cmd_payload, busy, err, dbg_state
    );

    modport slave (
        output rx_data, rx_data_rdy, cmd_ready,
        input  cmd_valid, cmd_opcode, cmd_payload, busy, err, dbg_state
    );

endinterface

// File: rtl/debug_cmd_reader.sv
// Decodes UART bytes into debug commands (opcode + little-endian 32-bit payload).
// Optional trailing XOR checksum byte enabled by DEBUG_CMD_CHECKSUM_EN.
module debug_cmd_reader
    import debug_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    debug_cmd_reader_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state;
    logic        r_rdy_d;
    logic [7:0]  r_opcode, w_opcode;
    logic [31:0] r_payload, w_payload;
    logic [1:0]  r_idx, w_idx;
    logic [TW-1:0] r_timer, w_timer;
    logic [2:0]  r_err, w_err;
    logic        w_acc;
`ifdef DEBUG_CMD_CHECKSUM_EN
    logic [7:0]  r_csum, w_csum;
`endif

    // A level held high on rx_data_rdy yields a single accepted byte.
    assign w_acc = bus.rx_data_rdy & ~r_rdy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rdy_d   <= 1'b0;
            r_opcode  <= '0;
            r_payload <= '0;
            r_idx     <= '0;
            r_timer   <= '0;
            r_err     <= '0;
`ifdef DEBUG_CMD_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_state   <= w_state;
            r_rdy_d   <= bus.rx_data_rdy;
            r_opcode  <= w_opcode;
            r_payload <= w_payload;
            r_idx     <= w_idx;
            r_timer   <= w_timer;
            r_err     <= w_err;
`ifdef DEBUG_CMD_CHECKSUM_EN
            r_csum    <= w_csum;
`endif
        end
    end

    always_comb begin
        w_state   = r_state;
        w_opcode  = r_opcode;
        w_payload = r_payload;
        w_idx     = r_idx;
        w_timer   = r_timer;
        w_err     = '0;
`ifdef DEBUG_CMD_CHECKSUM_EN
        w_csum    = r_csum;
`endif
        case (r_state)
            ST_IDLE: begin
                w_timer = '0;
                if (w_acc) begin
                    case (bus.rx_data)
                        OP_A, OP_R, OP_S: begin
                            w_opcode  = bus.rx_data;
                            w_payload = '0;
`ifdef DEBUG_CMD_CHECKSUM_EN
                            w_csum    = bus.rx_data;
                            w_state   = ST_CHECK;
`else
                            w_state   = ST_HOLD;
`endif
                        end
                        OP_M, OP_B: begin
                            w_opcode  = bus.rx_data;
                            w_payload = '0;
                            w_idx     = '0;
`ifdef DEBUG_CMD_CHECKSUM_EN
                            w_csum    = bus.rx_data;
`endif
                            w_state   = ST_PAYLOAD;
                        end
                        default: w_err[ERR_UNKNOWN] = 1'b1;
                    endcase
                end
            end
            ST_PAYLOAD: begin
                // An accepted byte takes priority over an expiring timeout.
                if (w_acc) begin
                    w_timer   = '0;
                    w_payload = {bus.rx_data, r_payload[31:8]};
                    w_idx     = r_idx + 2'd1;
`ifdef DEBUG_CMD_CHECKSUM_EN
                    w_csum    = r_csum ^ bus.rx_data;
                    if (r_idx == 2'd3) w_state = ST_CHECK;
`else
                    if (r_idx == 2'd3) w_state = ST_HOLD;
`endif
                end else if (r_timer == TMAX) begin
                    w_err[ERR_TIMEOUT] = 1'b1;
                    w_timer = '0;
                    w_state = ST_IDLE;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
`ifdef DEBUG_CMD_CHECKSUM_EN
            ST_CHECK: begin
                if (w_acc) begin
                    w_timer = '0;
                    if (bus.rx_data == r_csum) begin
                        w_state = ST_HOLD;
                    end else begin
                        w_err[ERR_OVERRUN] = 1'b1;
                        w_state = ST_IDLE;
                    end
                end else if (r_timer == TMAX) begin
                    w_err[ERR_TIMEOUT] = 1'b1;
                    w_timer = '0;
                    w_state = ST_IDLE;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
`endif
            ST_HOLD: begin
                w_timer = '0;
                if (w_acc) w_err[ERR_OVERRUN] = 1'b1;
                if (bus.cmd_ready) w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign bus.cmd_valid   = (r_state == ST_HOLD);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.cmd_opcode  = r_opcode;
    assign bus.cmd_payload = r_payload;
    assign bus.err         = r_err;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_debug_cmd_reader.sv
// Directed bench for debug_cmd_reader with TIMEOUT_CYCLES = 16; adds checksum bytes when DEBUG_CMD_CHECKSUM_EN is defined.
module tb_debug_cmd_reader;
    import debug_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [39:0] exp_q[$];

    debug_cmd_reader_if bus_if();

    debug_cmd_reader #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the byte is accepted on the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data     = b;
        bus_if.rx_data_rdy = 1'b1;
        @(negedge clk);
        bus_if.rx_data_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] pl, input bit has_pl);
        logic [7:0] cs;
        cs = op;
        send_byte(op);
        if (has_pl) begin
            for (int i = 0; i < 4; i++) begin
                idle(1);
                send_byte(pl[8*i +: 8]);
                cs = cs ^ pl[8*i +: 8];
            end
        end
`ifdef DEBUG_CMD_CHECKSUM_EN
        idle(1);
        send_byte(cs);
`endif
        exp_q.push_back({op, (has_pl ? pl : 32'h0)});
    endtask

    task automatic expect_cmd(input string tag);
        logic [39:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_valid"},   32'(bus_if.cmd_valid), 32'd1);
        check({tag, "_opcode"},  32'(bus_if.cmd_opcode), 32'(e[39:32]));
        check({tag, "_payload"}, bus_if.cmd_payload, e[31:0]);
        bus_if.cmd_ready = 1'b1;
        idle(1);
        check({tag, "_valid_fall"}, 32'(bus_if.cmd_valid), 32'd0);
        check({tag, "_busy_fall"},  32'(bus_if.busy), 32'd0);
        bus_if.cmd_ready = 1'b0;
    endtask

    initial begin
        int extra_err;
        bus_if.rx_data     = 8'h00;
        bus_if.rx_data_rdy = 1'b0;
        bus_if.cmd_ready   = 1'b0;

        // Reset state
        idle(3);
        check("rst_valid",   32'(bus_if.cmd_valid), 32'd0);
        check("rst_busy",    32'(bus_if.busy), 32'd0);
        check("rst_err",     32'(bus_if.err), 32'd0);
        check("rst_opcode",  32'(bus_if.cmd_opcode), 32'd0);
        check("rst_payload", bus_if.cmd_payload, 32'd0);
        check("rst_state",   32'(bus_if.dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        idle(1);

        // 'A' -> opcode 0x41, payload 0
        send_frame(8'h41, 32'h0, 1'b0);
        check("a_busy", 32'(bus_if.busy), 32'd1);
        expect_cmd("a");
        idle(1);

        // 'M' little-endian payload
        send_frame(8'h4D, 32'h12345678, 1'b1);
        expect_cmd("m");
        idle(1);

        // Timeout after 'M',0x01: err[1] exactly 16 idle cycles after the last accepted byte
        send_byte(8'h4D);
        idle(1);
        send_byte(8'h01);
        idle(15);
        check("to_busy_before", 32'(bus_if.busy), 32'd1);
        check("to_err_before",  32'(bus_if.err), 32'd0);
        idle(1);
        check("to_err",  32'(bus_if.err), 32'b010);
        check("to_busy", 32'(bus_if.busy), 32'd0);
        idle(1);
        check("to_err_clear", 32'(bus_if.err), 32'd0);
        send_frame(8'h41, 32'h0, 1'b0);
        expect_cmd("a_after_to");
        idle(1);

        // Byte arriving on the expiring cycle wins
        send_byte(8'h4D);
        idle(1);
        send_byte(8'hAA);
        idle(15);
        send_byte(8'hBB);
        check("win_err",   32'(bus_if.err), 32'd0);
        check("win_busy",  32'(bus_if.busy), 32'd1);
        check("win_state", 32'(bus_if.dbg_state), 32'(ST_PAYLOAD));
        idle(1);
        send_byte(8'hCC);
        idle(1);
        send_byte(8'hDD);
`ifdef DEBUG_CMD_CHECKSUM_EN
        idle(1);
        send_byte(8'h4D ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
        exp_q.push_back({8'h4D, 32'hDDCCBBAA});
        expect_cmd("win");
        idle(1);

        // Unknown opcode 'X'
        send_byte(8'h58);
        check("x_err",   32'(bus_if.err), 32'b001);
        check("x_valid", 32'(bus_if.cmd_valid), 32'd0);
        check("x_busy",  32'(bus_if.busy), 32'd0);
        idle(1);
        check("x_err_clear", 32'(bus_if.err), 32'd0);

        // 'R' held, then 'S' dropped
        send_frame(8'h52, 32'h0, 1'b0);
        idle(1);
        send_byte(8'h53);
        check("ovr_err",    32'(bus_if.err), 32'b100);
        check("ovr_valid",  32'(bus_if.cmd_valid), 32'd1);
        check("ovr_opcode", 32'(bus_if.cmd_opcode), 32'h52);
        idle(1);
        check("ovr_err_clear", 32'(bus_if.err), 32'd0);
        check("ovr_opcode2",   32'(bus_if.cmd_opcode), 32'h52);
        expect_cmd("r");
        idle(1);

        // rx_data_rdy held high 10 cycles counts once
        bus_if.rx_data     = 8'h58;
        bus_if.rx_data_rdy = 1'b1;
        idle(1);
        check("lvl_first", 32'(bus_if.err), 32'b001);
        extra_err = 0;
        for (int i = 0; i < 9; i++) begin
            idle(1);
            if (bus_if.err != 3'b000) extra_err++;
        end
        bus_if.rx_data_rdy = 1'b0;
        check("lvl_extra", 32'(extra_err), 32'd0);
        idle(1);

`ifdef DEBUG_CMD_CHECKSUM_EN
        // Good checksum 0x46 and bad checksum 0x00
        send_frame(8'h42, 32'h04030201, 1'b1);
        expect_cmd("b_ok");
        idle(1);
        send_byte(8'h42);
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            send_byte(8'(i));
        end
        idle(1);
        send_byte(8'h00);
        check("cs_err",   32'(bus_if.err), 32'b100);
        check("cs_valid", 32'(bus_if.cmd_valid), 32'd0);
        check("cs_busy",  32'(bus_if.busy), 32'd0);
        idle(1);
`endif

        // Reset mid-frame discards it; next byte is an opcode
        send_byte(8'h4D);
        idle(1);
        send_byte(8'h11);
        rst = 1'b1;
        idle(1);
        check("mrst_busy",  32'(bus_if.busy), 32'd0);
        check("mrst_state", 32'(bus_if.dbg_state), 32'(ST_IDLE));
        check("mrst_err",   32'(bus_if.err), 32'd0);
        rst = 1'b0;
        idle(1);
        send_frame(8'h41, 32'h0, 1'b0);
        expect_cmd("a_after_rst");
        idle(2);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
